// File: rtl/hand_reg_bank.sv
// hand_reg_bank: per-hand card register bank with running Baccarat score.
// Replaces the discrete player/dealer card registers and score blocks.
// One addressed load port writes one card per slow_clock edge; illegal
// loads are rejected and latched in a sticky err flag.
module hand_reg_bank #(
    parameter  int NUM_HANDS = 2,
    parameter  int SLOTS     = 3,
    localparam int HAND_W    = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
    localparam int SLOT_W    = (SLOTS > 1) ? $clog2(SLOTS) : 1,
    localparam int CNT_W     = $clog2(SLOTS + 1)
) (
    input  logic                         slow_clock,
    input  logic                         resetb,
    input  logic                         clear,
    input  logic                         load,
    input  logic [HAND_W-1:0]            load_hand,
    input  logic [SLOT_W-1:0]            load_slot,
    input  logic [3:0]                   card_in,
    output logic [NUM_HANDS*SLOTS*4-1:0] cards_out,
    output logic [NUM_HANDS*4-1:0]       scores_out,
    output logic [NUM_HANDS*CNT_W-1:0]   counts_out,
    output logic [NUM_HANDS-1:0]         full_out,
    output logic [NUM_HANDS-1:0]         natural_out,
    output logic                         err
);

    // Baccarat value of a card code: 1..9 count face value, 10/J/Q/K count zero.
    function automatic logic [3:0] card_value(input logic [3:0] code);
        logic [3:0] v;
        if ((code >= 4'd1) && (code <= 4'd9)) begin
            v = code;
        end else begin
            v = 4'd0;
        end
        return v;
    endfunction

    // Mod-10 accumulate: both operands are below 10, so one conditional
    // subtraction of 10 from the 5-bit sum is enough.
    function automatic logic [3:0] score_add(input logic [3:0] score, input logic [3:0] code);
        logic [4:0] sum;
        sum = {1'b0, score} + {1'b0, card_value(code)};
        if (sum >= 5'd10) begin
            sum = sum - 5'd10;
        end else begin
            sum = sum;
        end
        return sum[3:0];
    endfunction

    logic [3:0]       cards_r  [NUM_HANDS][SLOTS];
    logic [3:0]       scores_r [NUM_HANDS];
    logic [CNT_W-1:0] counts_r [NUM_HANDS];
    logic             err_r;

    logic hit_s;
    logic occupied_s;
    logic card_ok_s;
    logic legal_s;
    logic illegal_s;

    // Load qualification: address must hit an existing slot (this also rejects
    // out-of-range hand/slot indices), the slot must be empty and the code legal.
    always_comb begin
        hit_s      = 1'b0;
        occupied_s = 1'b0;
        for (int h = 0; h < NUM_HANDS; h++) begin
            for (int s = 0; s < SLOTS; s++) begin
                hit_s      = hit_s | ((load_hand == HAND_W'(h)) && (load_slot == SLOT_W'(s)));
                occupied_s = occupied_s | ((load_hand == HAND_W'(h)) && (load_slot == SLOT_W'(s))
                                           && (cards_r[h][s] != 4'd0));
            end
        end
        card_ok_s = (card_in != 4'd0) && (card_in <= 4'd13);
        legal_s   = load & hit_s & ~occupied_s & card_ok_s;
        illegal_s = load & ~legal_s;
    end

    // Card storage: write the addressed slot on a legal load; clear wipes all.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            for (int h = 0; h < NUM_HANDS; h++)
                for (int s = 0; s < SLOTS; s++)
                    cards_r[h][s] <= 4'd0;
        end else if (clear) begin
            for (int h = 0; h < NUM_HANDS; h++)
                for (int s = 0; s < SLOTS; s++)
                    cards_r[h][s] <= 4'd0;
        end else begin
            for (int h = 0; h < NUM_HANDS; h++)
                for (int s = 0; s < SLOTS; s++)
                    if (legal_s && (load_hand == HAND_W'(h)) && (load_slot == SLOT_W'(s)))
                        cards_r[h][s] <= card_in;
        end
    end

    // Per-hand running score and occupancy count, updated with each legal load.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            for (int h = 0; h < NUM_HANDS; h++) begin
                scores_r[h] <= 4'd0;
                counts_r[h] <= '0;
            end
        end else if (clear) begin
            for (int h = 0; h < NUM_HANDS; h++) begin
                scores_r[h] <= 4'd0;
                counts_r[h] <= '0;
            end
        end else begin
            for (int h = 0; h < NUM_HANDS; h++) begin
                if (legal_s && (load_hand == HAND_W'(h))) begin
                    scores_r[h] <= score_add(scores_r[h], card_in);
                    counts_r[h] <= counts_r[h] + CNT_W'(1);
                end
            end
        end
    end

    // Sticky illegal-load flag; a load dropped by clear never sets it.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            err_r <= 1'b0;
        end else if (clear) begin
            err_r <= 1'b0;
        end else if (illegal_s) begin
            err_r <= 1'b1;
        end
    end

    // Flatten registered state onto the output buses; full/natural derive
    // combinationally from registered count and score.
    for (genvar h = 0; h < NUM_HANDS; h++) begin : g_hand
        assign scores_out[h*4 +: 4]          = scores_r[h];
        assign counts_out[h*CNT_W +: CNT_W]  = counts_r[h];
        assign full_out[h]                   = (counts_r[h] == CNT_W'(SLOTS));
        assign natural_out[h]                = (counts_r[h] == CNT_W'(2)) && (scores_r[h] >= 4'd8);
        for (genvar s = 0; s < SLOTS; s++) begin : g_slot
            assign cards_out[(h*SLOTS+s)*4 +: 4] = cards_r[h][s];
        end
    end

    assign err = err_r;

endmodule

// File: tb/tb_hand_reg_bank.sv
// Self-checking bench for hand_reg_bank: a default (2x3) instance and a
// 4x5 instance, each compared against a card-array reference model whose
// score/count/flags are recomputed from the stored cards.
module tb_hand_reg_bank;

    logic slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    logic resetb;

    // Default instance (NUM_HANDS=2, SLOTS=3)
    logic        a_clear, a_load;
    logic [0:0]  a_hand;
    logic [1:0]  a_slot;
    logic [3:0]  a_card;
    logic [23:0] a_cards;
    logic [7:0]  a_scores;
    logic [3:0]  a_counts;
    logic [1:0]  a_full, a_nat;
    logic        a_err;
    logic [40:0] obs_a;

    // Swept instance (NUM_HANDS=4, SLOTS=5)
    logic        b_clear, b_load;
    logic [1:0]  b_hand;
    logic [2:0]  b_slot;
    logic [3:0]  b_card;
    logic [79:0] b_cards;
    logic [15:0] b_scores;
    logic [11:0] b_counts;
    logic [3:0]  b_full, b_nat;
    logic        b_err;
    logic [116:0] obs_b;

    hand_reg_bank dut_a (
        .slow_clock(slow_clock), .resetb(resetb), .clear(a_clear), .load(a_load),
        .load_hand(a_hand), .load_slot(a_slot), .card_in(a_card),
        .cards_out(a_cards), .scores_out(a_scores), .counts_out(a_counts),
        .full_out(a_full), .natural_out(a_nat), .err(a_err)
    );

    hand_reg_bank #(.NUM_HANDS(4), .SLOTS(5)) dut_b (
        .slow_clock(slow_clock), .resetb(resetb), .clear(b_clear), .load(b_load),
        .load_hand(b_hand), .load_slot(b_slot), .card_in(b_card),
        .cards_out(b_cards), .scores_out(b_scores), .counts_out(b_counts),
        .full_out(b_full), .natural_out(b_nat), .err(b_err)
    );

    assign obs_a = {a_cards, a_scores, a_counts, a_full, a_nat, a_err};
    assign obs_b = {b_cards, b_scores, b_counts, b_full, b_nat, b_err};

    int checks = 0;
    int errors = 0;

    // Reference model: just the cards held and the error flag.
    int ma_cards [2][3];
    bit ma_err;
    int mb_cards [4][5];
    bit mb_err;

    function automatic int val(input int c);
        return (c >= 1 && c <= 9) ? c : 0;
    endfunction

    function automatic logic [40:0] exp_a();
        logic [23:0] cd; logic [7:0] sc; logic [3:0] cn; logic [1:0] fu, na;
        for (int h = 0; h < 2; h++) begin
            int sum = 0; int n = 0;
            for (int s = 0; s < 3; s++) begin
                cd[(h*3+s)*4 +: 4] = 4'(ma_cards[h][s]);
                sum += val(ma_cards[h][s]);
                if (ma_cards[h][s] != 0) n++;
            end
            sc[h*4 +: 4] = 4'(sum % 10);
            cn[h*2 +: 2] = 2'(n);
            fu[h] = (n == 3);
            na[h] = (n == 2) && ((sum % 10) >= 8);
        end
        return {cd, sc, cn, fu, na, ma_err};
    endfunction

    function automatic logic [116:0] exp_b();
        logic [79:0] cd; logic [15:0] sc; logic [11:0] cn; logic [3:0] fu, na;
        for (int h = 0; h < 4; h++) begin
            int sum = 0; int n = 0;
            for (int s = 0; s < 5; s++) begin
                cd[(h*5+s)*4 +: 4] = 4'(mb_cards[h][s]);
                sum += val(mb_cards[h][s]);
                if (mb_cards[h][s] != 0) n++;
            end
            sc[h*4 +: 4] = 4'(sum % 10);
            cn[h*3 +: 3] = 3'(n);
            fu[h] = (n == 5);
            na[h] = (n == 2) && ((sum % 10) >= 8);
        end
        return {cd, sc, cn, fu, na, mb_err};
    endfunction

    task automatic model_reset();
        for (int h = 0; h < 2; h++) for (int s = 0; s < 3; s++) ma_cards[h][s] = 0;
        for (int h = 0; h < 4; h++) for (int s = 0; s < 5; s++) mb_cards[h][s] = 0;
        ma_err = 1'b0;
        mb_err = 1'b0;
    endtask

    // Drive one cycle on instance A and advance the model at the edge.
    task automatic step_a(input bit clr, input bit ld, input int h, input int s, input int c);
        a_clear = clr; a_load = ld; a_hand = h[0:0]; a_slot = s[1:0]; a_card = c[3:0];
        @(posedge slow_clock);
        if (clr) begin
            for (int i = 0; i < 2; i++) for (int j = 0; j < 3; j++) ma_cards[i][j] = 0;
            ma_err = 1'b0;
        end else if (ld) begin
            if (h < 2 && s < 3 && c >= 1 && c <= 13 && ma_cards[h][s] == 0) ma_cards[h][s] = c;
            else ma_err = 1'b1;
        end
        #1;
        a_clear = 1'b0; a_load = 1'b0;
    endtask

    task automatic step_b(input bit clr, input bit ld, input int h, input int s, input int c);
        b_clear = clr; b_load = ld; b_hand = h[1:0]; b_slot = s[2:0]; b_card = c[3:0];
        @(posedge slow_clock);
        if (clr) begin
            for (int i = 0; i < 4; i++) for (int j = 0; j < 5; j++) mb_cards[i][j] = 0;
            mb_err = 1'b0;
        end else if (ld) begin
            if (h < 4 && s < 5 && c >= 1 && c <= 13 && mb_cards[h][s] == 0) mb_cards[h][s] = c;
            else mb_err = 1'b1;
        end
        #1;
        b_clear = 1'b0; b_load = 1'b0;
    endtask

    task automatic test_reset();
        resetb = 1'b0;
        model_reset();
        #12;
        checks++;
        if (obs_a !== 41'd0 || obs_b !== 117'd0) begin
            errors++;
            $display("FAIL reset_asserted: got a=%h b=%h expected all zero", obs_a, obs_b);
        end
        @(negedge slow_clock);
        resetb = 1'b1;
        repeat (2) @(negedge slow_clock);
        checks++;
        if (obs_a !== exp_a() || obs_b !== exp_b()) begin
            errors++;
            $display("FAIL reset_idle: got a=%h b=%h expected a=%h b=%h", obs_a, obs_b, exp_a(), exp_b());
        end
    endtask

    task automatic test_natural();
        int hand_cards [3] = '{7, 1, 13};
        for (int i = 0; i < 3; i++) begin
            step_a(1'b0, 1'b1, 0, i, hand_cards[i]);
            @(negedge slow_clock);
            checks++;
            if (obs_a !== exp_a()) begin
                errors++;
                $display("FAIL natural_load%0d: got %h expected %h", i, obs_a, exp_a());
            end
        end
        checks++;
        if (a_scores[3:0] !== 4'd8 || a_counts[1:0] !== 2'd3 || a_full[0] !== 1'b1 || a_nat[0] !== 1'b0) begin
            errors++;
            $display("FAIL natural_third: got score=%0d count=%0d full=%b nat=%b expected 8 3 1 0",
                     a_scores[3:0], a_counts[1:0], a_full[0], a_nat[0]);
        end
    endtask

    task automatic test_natural_two();
        step_a(1'b1, 1'b0, 0, 0, 0);
        step_a(1'b0, 1'b1, 0, 0, 7);
        step_a(1'b0, 1'b1, 0, 1, 1);
        @(negedge slow_clock);
        checks++;
        if (a_scores[3:0] !== 4'd8 || a_counts[1:0] !== 2'd2 || a_nat[0] !== 1'b1 || a_full[0] !== 1'b0) begin
            errors++;
            $display("FAIL natural_two: got score=%0d count=%0d nat=%b full=%b expected 8 2 1 0",
                     a_scores[3:0], a_counts[1:0], a_nat[0], a_full[0]);
        end
        step_a(1'b0, 1'b1, 0, 2, 13);
    endtask

    task automatic test_wrap();
        int hand_cards [3] = '{9, 6, 8};
        int seq [3]        = '{9, 5, 3};
        for (int i = 0; i < 3; i++) begin
            step_a(1'b0, 1'b1, 1, i, hand_cards[i]);
            @(negedge slow_clock);
            checks++;
            if (obs_a !== exp_a() || a_scores[7:4] !== 4'(seq[i])) begin
                errors++;
                $display("FAIL wrap_step%0d: got %h score1=%0d expected %h score1=%0d",
                         i, obs_a, a_scores[7:4], exp_a(), seq[i]);
            end
        end
    endtask

    task automatic test_illegal();
        for (int i = 0; i < 3; i++) begin
            step_a(1'b1, 1'b0, 0, 0, 0);
            if (i == 0) begin
                step_a(1'b0, 1'b1, 0, 0, 7);
                step_a(1'b0, 1'b1, 0, 0, 4);
            end else if (i == 1) begin
                step_a(1'b0, 1'b1, 0, 0, 14);
            end else begin
                step_a(1'b0, 1'b1, 0, 3, 5);
            end
            @(negedge slow_clock);
            checks++;
            if (obs_a !== exp_a() || a_err !== 1'b1) begin
                errors++;
                $display("FAIL illegal_case%0d: got %h err=%b expected %h err=1", i, obs_a, a_err, exp_a());
            end
        end
        step_a(1'b0, 1'b1, 1, 0, 2);
        @(negedge slow_clock);
        checks++;
        if (obs_a !== exp_a() || a_err !== 1'b1 || a_cards[15:12] !== 4'd2) begin
            errors++;
            $display("FAIL illegal_then_legal: got %h expected %h", obs_a, exp_a());
        end
    endtask

    task automatic test_clear_and_reset();
        step_a(1'b1, 1'b1, 0, 0, 5);
        @(negedge slow_clock);
        checks++;
        if (obs_a !== exp_a() || obs_a !== 41'd0) begin
            errors++;
            $display("FAIL clear_priority: got %h expected 0", obs_a);
        end
        step_a(1'b0, 1'b1, 0, 0, 5);
        step_a(1'b0, 1'b1, 1, 1, 9);
        step_b(1'b0, 1'b1, 3, 4, 6);
        #2;
        resetb = 1'b0;
        #1;
        model_reset();
        checks++;
        if (obs_a !== exp_a() || obs_b !== exp_b() || obs_a !== 41'd0) begin
            errors++;
            $display("FAIL async_reset: got a=%h b=%h expected zero", obs_a, obs_b);
        end
        @(negedge slow_clock);
        resetb = 1'b1;
        step_a(1'b0, 1'b1, 1, 2, 3);
        @(negedge slow_clock);
        checks++;
        if (obs_a !== exp_a()) begin
            errors++;
            $display("FAIL after_reset_load: got %h expected %h", obs_a, exp_a());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bit clr = ($urandom_range(0, 15) == 0);
            bit ld  = ($urandom_range(0, 3) != 0);
            step_a(clr, ld, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 15));
            @(negedge slow_clock);
            checks++;
            if (obs_a !== exp_a()) begin
                errors++;
                $display("FAIL random_%0d: got %h expected %h", i, obs_a, exp_a());
            end
        end
    endtask

    task automatic test_sweep();
        int ord [20];
        for (int i = 0; i < 20; i++) ord[i] = i;
        for (int i = 19; i > 0; i--) begin
            int j = $urandom_range(0, i);
            int t = ord[i];
            ord[i] = ord[j];
            ord[j] = t;
        end
        step_b(1'b1, 1'b0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step_b(1'b0, 1'b1, ord[i] / 5, ord[i] % 5, $urandom_range(1, 13));
            @(negedge slow_clock);
            checks++;
            if (obs_b !== exp_b()) begin
                errors++;
                $display("FAIL sweep_random_%0d: got %h expected %h", i, obs_b, exp_b());
            end
        end
        step_b(1'b1, 1'b0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step_b(1'b0, 1'b1, ord[i] / 5, ord[i] % 5, 10);
        @(negedge slow_clock);
        checks++;
        if (obs_b !== exp_b() || b_scores !== 16'h0000 || b_counts !== {4{3'd5}}
            || b_full !== 4'hF || b_err !== 1'b0) begin
            errors++;
            $display("FAIL sweep_tens: got scores=%h counts=%h full=%b err=%b expected 0 %h 1111 0",
                     b_scores, b_counts, b_full, b_err, {4{3'd5}});
        end
    endtask

    initial begin
        a_clear = 1'b0; a_load = 1'b0; a_hand = '0; a_slot = '0; a_card = '0;
        b_clear = 1'b0; b_load = 1'b0; b_hand = '0; b_slot = '0; b_card = '0;
        resetb = 1'b0;
        model_reset();
        test_reset();
        test_natural_two();
        test_natural();
        test_wrap();
        test_illegal();
        test_clear_and_reset();
        test_random();
        test_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hand_reg_bank.md
Name: hand_reg_bank

Overview:
- Parametrised successor to the single-card 4-bit register.
- Holds NUM_HANDS hands of SLOTS card registers each.
- Loads cards through one addressed load port and keeps a running Baccarat score per hand (sum of card values mod 10).
- Flags occupancy, naturals and illegal loads.
- Sits between dealcard and the card7seg/HEX display logic in the datapath. It replaces the discrete pcard/dcard registers and the scorehand blocks.

Parameters:
- NUM_HANDS, 2, number of hands (hand 0 = player, hand 1 = dealer).
- SLOTS, 3, card slots per hand (≥2).
- HAND_W, max(1,$clog2(NUM_HANDS)), hand index width (derived).
- SLOT_W, max(1,$clog2(SLOTS)), slot index width (derived).
- CNT_W, $clog2(SLOTS+1), card-count width (derived).

Ports:
- slow_clock  in  1  clock; all state changes on its rising edge.
- resetb  in  1  reset: asynchronous, active-low.
- clear  in  1  synchronous new-round clear.
- load  in  1  load strobe, one card per cycle.
- load_hand  in  HAND_W  target hand index.
- load_slot  in  SLOT_W  target slot index.
- card_in  in  4  card code from dealcard.
- cards_out  out  NUM_HANDS*SLOTS*4  stored card codes; hand h, slot s at bits [(h*SLOTS+s)*4 +: 4].
- scores_out  out  NUM_HANDS*4  running score per hand, 0..9.
- counts_out  out  NUM_HANDS*CNT_W  number of occupied slots per hand.
- full_out  out  NUM_HANDS  1 when all slots of that hand are occupied.
- natural_out  out  NUM_HANDS  1 when the hand has exactly 2 cards and score is 8 or 9.
- err  out  1  sticky illegal-load flag.

Behaviour:
- Card codes:
  - 0 = empty slot.
  - 1 = Ace, 2..10 = pip cards, 11/12/13 = J/Q/K.
  - 14 and 15 are illegal.
- Card value: code 1..9 gives value = code; codes 10..13 give value 0.
- Reset (resetb=0, async): all card registers 0, all scores 0, all counts 0, err 0.
  - Consequently full_out=0 and natural_out=0.
  - On resetb deassertion, normal operation resumes at the next rising edge. Reset mid-round discards all cards.
- Legal load: load=1, hand < NUM_HANDS, slot < SLOTS, slot currently empty, card_in in 1..13. On that edge:
  - card register ← card_in;
  - count[hand] += 1;
  - score[hand] ← (score[hand] + value) mod 10. Computed as a 5-bit sum; subtract 10 if the sum is ≥10; the result is always 0..9.
  - Latency: all outputs reflect the load one slow_clock edge after the strobe (registered outputs; natural_out/full_out combinational from registered count/score).
- Illegal load (any one of: out-of-range hand or slot, occupied slot, card_in ∈ {0,14,15}):
  - no card, score or count change;
  - err ← 1 on that edge.
- err is sticky. Only resetb or clear clear it.
- clear=1: all cards, scores and counts ← 0; err ← 0.
  - clear has priority over a simultaneous load. That load is dropped and does not set err.
- load=0: state holds; load_hand/load_slot/card_in are don't-care.
- Slots may be filled in any order. count is the number of occupied slots, not the highest slot index.
- Score is order-independent (mod-10 sum).
- No wrap of count: count ≤ SLOTS is guaranteed because occupied slots reject loads.
- All state is per-hand independent. A load to hand h never alters any other hand.

Test Plan:
- Reset then idle → cards_out=0, scores_out=0, counts_out=0, err=0, natural_out=00.
- Load hand0 slot0=7 then hand0 slot1=1 → after 2nd edge score0=8, count0=2, natural_out[0]=1. Then hand0 slot2=13 → score0=8, count0=3, natural_out[0]=0, full_out[0]=1.
- Load hand1 cards 9, 6, 8 → score1 sequence 9, 5, 3 (wrap at 15 and 13). Hand0 untouched throughout.
- Illegal loads, each starting from a cleared state: reload occupied hand0 slot0 with 4; card_in=14; load_slot=3 with SLOTS=3 → err=1, card and score unchanged. A following legal load still works with err still 1.
- Same cycle clear=1 and load=1 (hand0 slot0=5) → next edge all zero, err=0, card not stored. Then assert resetb=0 asynchronously mid-round with cards loaded → outputs zero immediately, before the next clock edge.
- Parameter sweep NUM_HANDS=4, SLOTS=5: fill all 20 slots with 10 → all scores 0, all counts 5, full_out=1111, bit packing of cards_out matches the index formula.
